// File: rtl/rom_pkg.sv
// Shared ROM geometry and the fetch-stage state encoding.
package rom_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_e;

endpackage

// File: rtl/rom.sv
// Combinational lookup ROM; contents are a fixed bijective byte pattern.
module rom #(
    parameter int ADDR_W = rom_pkg::ADDR_W,
    parameter int DATA_W = rom_pkg::DATA_W
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out
);

    always_comb begin
        data_out = DATA_W'((32'(addr) * 32'd7) ^ 32'h5A);
    end

endmodule

// File: rtl/rom_reader.sv
// Fetch stage: walks the ROM address port for a burst and streams the
// returned bytes out on a valid/ready interface with a last marker.
module rom_reader
    import rom_pkg::*;
#(
    parameter int ADDR_W = rom_pkg::ADDR_W,
    parameter int DATA_W = rom_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                load;
    logic                fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;
        fire        = out_valid_q & out_ready;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        rom_addr_d  = start_addr;
                        remaining_d = length;
                        busy_d      = 1'b1;
                        state_d     = S_STREAM;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                // Refill the output register whenever it is empty or draining.
                load = (remaining_q != '0) && (!out_valid_q || out_ready);
                if (load) begin
                    out_data_d  = rom_data;
                    out_valid_d = 1'b1;
                    out_last_d  = (remaining_q == (ADDR_W+1)'(1));
                    rom_addr_d  = rom_addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end else if (fire) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (fire && out_last_q) begin
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rom_addr  = rom_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
